uart_rx_frame: RTL and testbench

UART_RX_FRAME -- requirements
Module: uart_rx_frame

---
 rtl/uart_rx_frame.sv | 136 +++++++++++++
 tb/tb_uart_rx_frame.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: synchronised line, falling-edge start detect, mid-bit sampling,
// one-cycle data_valid / frame_err pulses, baud divisor latched per frame.
`timescale 1ns/1ps
module uart_rx_frame #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       src_clk,
   input  logic       rst,
   input  logic [1:0] baud_sel,
   input  logic       rx_en,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int DIV_9600   = CLK_HZ / 9600;
   localparam int DIV_57600  = CLK_HZ / 57600;
   localparam int DIV_115200 = CLK_HZ / 115200;
   localparam int CW = ($clog2(DIV_9600 + 1) < 13) ? 13 : $clog2(DIV_9600 + 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic          rx_m, rx_s, rx_p;
   logic [CW-1:0] cnt, cnt_n;
   logic [CW-1:0] div_q, div_n, div_sel;
   logic [CW-1:0] half_m1, div_m1;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shift_q, shift_n;
   logic [7:0]    data_n;
   logic          dv_n, fe_n;

   always_comb begin
      case (baud_sel)
         2'b01:   div_sel = CW'(DIV_57600);
         2'b10:   div_sel = CW'(DIV_115200);
         default: div_sel = CW'(DIV_9600);
      endcase
   end

   assign half_m1 = (div_q >> 1) - CW'(1);
   assign div_m1  = div_q - CW'(1);

   always_comb begin
      state_n   = state;
      cnt_n     = cnt + CW'(1);
      div_n     = div_q;
      bit_idx_n = bit_idx;
      shift_n   = shift_q;
      data_n    = data;
      dv_n      = 1'b0;
      fe_n      = 1'b0;
      // Disabling the receiver drops any partial byte silently.
      if (!rx_en) begin
         state_n   = IDLE;
         cnt_n     = '0;
         bit_idx_n = '0;
         shift_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               cnt_n = '0;
               if (rx_p && !rx_s) begin
                  state_n = START;
                  div_n   = div_sel;
               end
            end
            START: begin
               if (cnt == half_m1) begin
                  cnt_n     = '0;
                  bit_idx_n = '0;
                  state_n   = rx_s ? IDLE : DATA;
               end
            end
            DATA: begin
               // LSB arrives first, so shifting right leaves bit 0 at the bottom.
               if (cnt == div_m1) begin
                  cnt_n     = '0;
                  shift_n   = {rx_s, shift_q[7:1]};
                  bit_idx_n = bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state_n = STOP;
               end
            end
            STOP: begin
               if (cnt == div_m1) begin
                  cnt_n   = '0;
                  state_n = IDLE;
                  if (rx_s) begin
                     data_n = shift_q;
                     dv_n   = 1'b1;
                  end else begin
                     fe_n   = 1'b1;
                  end
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge src_clk) begin
      if (rst) begin
         rx_m       <= 1'b1;
         rx_s       <= 1'b1;
         rx_p       <= 1'b1;
         state      <= IDLE;
         cnt        <= '0;
         div_q      <= CW'(DIV_9600);
         bit_idx    <= '0;
         shift_q    <= '0;
         data       <= 8'h00;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rx_m       <= rx;
         rx_s       <= rx_m;
         rx_p       <= rx_s;
         state      <= state_n;
         cnt        <= cnt_n;
         div_q      <= div_n;
         bit_idx    <= bit_idx_n;
         shift_q    <= shift_n;
         data       <= data_n;
         data_valid <= dv_n;
         frame_err  <= fe_n;
         busy       <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at a 2 MHz clock: divisors 208/34/17, halves 104/17/8.
`timescale 1ns/1ps
module tb_uart_rx_frame;

   localparam int CLK_HZ = 2_000_000;

   logic       src_clk = 1'b0;
   logic       rst;
   logic [1:0] baud_sel;
   logic       rx_en;
   logic       rx;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       busy;

   uart_rx_frame #(.CLK_HZ(CLK_HZ)) dut (
      .src_clk    (src_clk),
      .rst        (rst),
      .baud_sel   (baud_sel),
      .rx_en      (rx_en),
      .rx         (rx),
      .data       (data),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 src_clk = ~src_clk;

   int cyc = 0;
   int dv_cnt = 0;
   int fe_cnt = 0;
   int dv_cyc = 0;
   int t_fall = 0;
   int n_vec = 0;
   int n_err = 0;

   always @(posedge src_clk) cyc++;

   always @(negedge src_clk) begin
      if (data_valid) begin
         dv_cnt++;
         dv_cyc = cyc;
      end
      if (frame_err) fe_cnt++;
   end

   typedef struct {
      logic [1:0] sel;
      logic [1:0] alt_sel;
      logic [7:0] val;
      logic       stop;
      int         gap;
      int         exp_dv;
      int         exp_fe;
      logic [7:0] exp_data;
      int         exp_lat;
   } vec_t;

   vec_t vecs[10];

   function automatic int bit_cycles(input logic [1:0] sel);
      case (sel)
         2'b01:   return 34;
         2'b10:   return 17;
         default: return 208;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge src_clk);
   endtask

   // Drives start plus the first nbits data bits; a full byte also gets its stop bit.
   task automatic applyStimulus(input logic [1:0] sel, input logic [1:0] alt_sel,
                                input logic [7:0] val, input logic stop, input int nbits);
      int d;
      d = bit_cycles(sel);
      baud_sel = sel;
      rx = 1'b0;
      t_fall = cyc;
      tick(5);
      baud_sel = alt_sel;
      tick(d - 5);
      for (int i = 0; i < nbits; i++) begin
         rx = val[i];
         tick(d);
      end
      if (nbits == 8) begin
         rx = stop;
         tick(d);
         rx = 1'b1;
      end
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected, input int tol);
      int diff;
      n_vec++;
      diff = actual - expected;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int dvb, feb;
      vecs[0] = '{2'd0, 2'd0, 8'h52, 1'b1, 50,  1, 0, 8'h52, 1979};
      vecs[1] = '{2'd0, 2'd0, 8'h52, 1'b1, 400, 1, 0, 8'h52, 1979};
      vecs[2] = '{2'd2, 2'd2, 8'hA5, 1'b1, 50,  1, 0, 8'hA5, 164};
      vecs[3] = '{2'd1, 2'd1, 8'h3C, 1'b1, 50,  1, 0, 8'h3C, 326};
      vecs[4] = '{2'd0, 2'd0, 8'h52, 1'b0, 50,  0, 1, 8'h3C, 0};
      vecs[5] = '{2'd3, 2'd3, 8'hC3, 1'b1, 50,  1, 0, 8'hC3, 1979};
      vecs[6] = '{2'd0, 2'd2, 8'h81, 1'b1, 50,  1, 0, 8'h81, 1979};
      vecs[7] = '{2'd2, 2'd0, 8'h00, 1'b1, 50,  1, 0, 8'h00, 164};
      vecs[8] = '{2'd1, 2'd1, 8'hFF, 1'b1, 0,   1, 0, 8'hFF, 326};
      vecs[9] = '{2'd1, 2'd1, 8'h5A, 1'b1, 0,   1, 0, 8'h5A, 326};

      rst = 1'b1;
      rx = 1'b1;
      rx_en = 1'b1;
      baud_sel = 2'b00;
      tick(3);
      rst = 1'b0;
      tick(1);
      checkOutput("reset_data", data, 8'h00, 0);
      checkOutput("reset_dv", data_valid, 0, 0);
      checkOutput("reset_fe", frame_err, 0, 0);
      checkOutput("reset_busy", busy, 0, 0);

      for (int i = 0; i < 10; i++) begin
         rx = 1'b1;
         tick(vecs[i].gap);
         dvb = dv_cnt;
         feb = fe_cnt;
         applyStimulus(vecs[i].sel, vecs[i].alt_sel, vecs[i].val, vecs[i].stop, 8);
         checkOutput($sformatf("vec%0d_dv_count", i), dv_cnt - dvb, vecs[i].exp_dv, 0);
         checkOutput($sformatf("vec%0d_fe_count", i), fe_cnt - feb, vecs[i].exp_fe, 0);
         checkOutput($sformatf("vec%0d_data", i), data, vecs[i].exp_data, 0);
         checkOutput($sformatf("vec%0d_busy_after", i), busy, 0, 0);
         if (vecs[i].exp_dv == 1)
            checkOutput($sformatf("vec%0d_latency", i), dv_cyc - t_fall, vecs[i].exp_lat, 2);
      end

      // Short low glitch at 9600: rejected at the half-bit check.
      tick(50);
      dvb = dv_cnt;
      feb = fe_cnt;
      baud_sel = 2'b00;
      rx = 1'b0;
      tick(20);
      checkOutput("glitch_busy_high", busy, 1, 0);
      rx = 1'b1;
      tick(200);
      checkOutput("glitch_dv", dv_cnt - dvb, 0, 0);
      checkOutput("glitch_fe", fe_cnt - feb, 0, 0);
      checkOutput("glitch_busy_low", busy, 0, 0);
      checkOutput("glitch_data", data, 8'h5A, 0);

      // rx_en dropped in the middle of bit 4.
      tick(50);
      dvb = dv_cnt;
      feb = fe_cnt;
      applyStimulus(2'b00, 2'b00, 8'h52, 1'b1, 4);
      tick(104);
      checkOutput("abort_en_busy_before", busy, 1, 0);
      rx_en = 1'b0;
      tick(1);
      checkOutput("abort_en_busy_after", busy, 0, 0);
      rx = 1'b1;
      tick(300);
      rx_en = 1'b1;
      tick(20);
      checkOutput("abort_en_dv", dv_cnt - dvb, 0, 0);
      checkOutput("abort_en_fe", fe_cnt - feb, 0, 0);
      checkOutput("abort_en_data_hold", data, 8'h5A, 0);
      dvb = dv_cnt;
      applyStimulus(2'b00, 2'b00, 8'h52, 1'b1, 8);
      checkOutput("abort_en_next_dv", dv_cnt - dvb, 1, 0);
      checkOutput("abort_en_next_data", data, 8'h52, 0);

      // Reset asserted in the middle of bit 4.
      tick(50);
      dvb = dv_cnt;
      feb = fe_cnt;
      applyStimulus(2'b00, 2'b00, 8'hA5, 1'b1, 4);
      tick(104);
      checkOutput("abort_rst_busy_before", busy, 1, 0);
      rst = 1'b1;
      rx = 1'b1;
      tick(1);
      checkOutput("abort_rst_busy_after", busy, 0, 0);
      checkOutput("abort_rst_data_cleared", data, 8'h00, 0);
      rst = 1'b0;
      tick(300);
      checkOutput("abort_rst_dv", dv_cnt - dvb, 0, 0);
      checkOutput("abort_rst_fe", fe_cnt - feb, 0, 0);
      checkOutput("abort_rst_busy_idle", busy, 0, 0);
      dvb = dv_cnt;
      feb = fe_cnt;
      applyStimulus(2'b00, 2'b00, 8'h52, 1'b1, 8);
      checkOutput("abort_rst_next_dv", dv_cnt - dvb, 1, 0);
      checkOutput("abort_rst_next_fe", fe_cnt - feb, 0, 0);
      checkOutput("abort_rst_next_data", data, 8'h52, 0);

      tick(10);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
